req_ack_target: RTL and testbench

REQ_ACK_TARGET -- requirements
Module: req_ack_target

---
 rtl/req_ack_target_pkg.sv | 13 +
 rtl/req_ack_target_ch.sv | 84 ++++++++
 rtl/req_ack_target.sv | 38 +++
 tb/tb_req_ack_target.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_target_pkg.sv
// Shared types and constants for the req/ack target channels.
package req_ack_target_pkg;

  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned LAT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } ch_state_t;

endpackage

// File: rtl/req_ack_target_ch.sv
// One req/ack channel: latency FSM, data capture, transfer counter.
// Optional protocol checker enabled by REQ_ACK_TARGET_CHECK_EN.
module req_ack_target_ch
  import req_ack_target_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACK_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  stall,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic                  err
);

  localparam bit FAST = (ACK_LATENCY == 1);
  localparam logic [LAT_WIDTH-1:0] LAT_LOAD =
    (ACK_LATENCY > 1) ? LAT_WIDTH'(ACK_LATENCY - 2) : '0;

  ch_state_t            state;
  logic [LAT_WIDTH-1:0] cnt;

  // Channel FSM; ack is registered so it is high exactly while in ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      last_data <= '0;
      xfer_cnt  <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (FAST && !stall) begin
              state <= ACK;
              ack   <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - LAT_WIDTH'(1);
          end else if (!stall) begin
            state <= ACK;
            ack   <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          if (req) begin
            last_data <= data;
            xfer_cnt  <= xfer_cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REQ_ACK_TARGET_CHECK_EN
  // Sticky flag: initiator abandoned the request before it completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (!req && (state == WAIT || state == ACK)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/req_ack_target.sv
// N_CH independent req/ack target channels sharing one clock and reset.
// Protocol checker per channel when REQ_ACK_TARGET_CHECK_EN is defined.
module req_ack_target
  import req_ack_target_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACK_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req,
  input  logic [N_CH*DATA_WIDTH-1:0] data,
  input  logic [N_CH-1:0]            stall,
  output logic [N_CH-1:0]            ack,
  output logic [N_CH*DATA_WIDTH-1:0] last_data,
  output logic [N_CH*CNT_WIDTH-1:0]  xfer_cnt,
  output logic [N_CH-1:0]            err
);

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    req_ack_target_ch #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ACK_LATENCY (ACK_LATENCY)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .req       (req[i]),
      .data      (data[i*DATA_WIDTH +: DATA_WIDTH]),
      .stall     (stall[i]),
      .ack       (ack[i]),
      .last_data (last_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .xfer_cnt  (xfer_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .err       (err[i])
    );
  end

endmodule

// File: tb/tb_req_ack_target.sv
// Scoreboard bench for req_ack_target: three instances (latency 1, 3, 4),
// expected acks queued by stimulus and checked by a negedge monitor.
module tb_req_ack_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REQ_ACK_TARGET_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        rst   [3];
  logic [1:0]  req   [3];
  logic [1:0]  stall [3];
  logic [1:0]  ack   [3];
  logic [1:0]  err   [3];
  logic [15:0] data  [3];
  logic [15:0] last  [3];
  logic [31:0] cnt   [3];

  req_ack_target #(.N_CH(2), .DATA_WIDTH(8), .ACK_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .data(data[0]), .stall(stall[0]),
    .ack(ack[0]), .last_data(last[0]), .xfer_cnt(cnt[0]), .err(err[0]));
  req_ack_target #(.N_CH(2), .DATA_WIDTH(8), .ACK_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .data(data[1]), .stall(stall[1]),
    .ack(ack[1]), .last_data(last[1]), .xfer_cnt(cnt[1]), .err(err[1]));
  req_ack_target #(.N_CH(2), .DATA_WIDTH(8), .ACK_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .data(data[2]), .stall(stall[2]),
    .ack(ack[2]), .last_data(last[2]), .xfer_cnt(cnt[2]), .err(err[2]));

  typedef struct {
    int          cyc;
    logic [7:0]  ld;
    logic [15:0] xc;
  } exp_t;

  exp_t        sb     [6][$];
  exp_t        pend_e [6];
  bit          pend   [6];
  logic [7:0]  m_ld   [6];
  logic [15:0] m_xc   [6];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one expected ack pulse on instance i, channel ch, lat cycles from now.
  task automatic expect_ack(int i, int ch, int lat, logic [7:0] d, bit xfer);
    int   k;
    exp_t e;
    k = i * 2 + ch;
    if (xfer) begin
      m_ld[k] = d;
      m_xc[k] = m_xc[k] + 16'd1;
    end
    e.cyc = cyc + lat;
    e.ld  = m_ld[k];
    e.xc  = m_xc[k];
    sb[k].push_back(e);
  endtask

  task automatic reset_model(int i);
    for (int ch = 0; ch < 2; ch++) begin
      m_ld[i*2+ch] = '0;
      m_xc[i*2+ch] = '0;
    end
  endtask

  // Monitor: pop on every ack, check timing, then check capture one cycle later.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      if (pend[k]) begin
        chk($sformatf("last_data i%0d ch%0d", k/2, k%2),
            32'(last[k/2][(k%2)*8 +: 8]), 32'(pend_e[k].ld));
        chk($sformatf("xfer_cnt i%0d ch%0d", k/2, k%2),
            32'(cnt[k/2][(k%2)*16 +: 16]), 32'(pend_e[k].xc));
        pend[k] = 1'b0;
      end
      if (ack[k/2][k%2]) begin
        if (sb[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack i%0d ch%0d actual=1 expected=0 (cycle %0d)",
                   k/2, k%2, cyc);
        end else begin
          e = sb[k].pop_front();
          chk($sformatf("ack_cycle i%0d ch%0d", k/2, k%2), 32'(cyc), 32'(e.cyc));
          pend_e[k] = e;
          pend[k]   = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = '0; stall[i] = '0; data[i] = '0;
      reset_model(i);
    end
    for (int k = 0; k < 6; k++) pend[k] = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ack i%0d", i),  32'(ack[i]),  32'd0);
      chk($sformatf("reset last i%0d", i), 32'(last[i]), 32'd0);
      chk($sformatf("reset cnt i%0d", i),  cnt[i],       32'd0);
      chk($sformatf("reset err i%0d", i),  32'(err[i]),  32'd0);
      rst[i] = 1'b0;
    end
    tick();

    // Latency 1: single transfer on ch0, ch1 untouched.
    data[0][7:0] = 8'h5A; req[0][0] = 1'b1;
    expect_ack(0, 0, 1, 8'h5A, 1);
    tick(); tick();
    req[0][0] = 1'b0;
    tick();
    chk("ch1 last untouched", 32'(last[0][15:8]), 32'd0);
    chk("ch1 cnt untouched",  32'(cnt[0][31:16]), 32'd0);

    // Latency 1: counter preloaded near the top, held req pulses every 2nd cycle.
    force dut1.gen_ch[0].u_ch.xfer_cnt = 16'hFFFE;
    tick();
    release dut1.gen_ch[0].u_ch.xfer_cnt;
    m_xc[0] = 16'hFFFE;
    chk("preload cnt", 32'(cnt[0][15:0]), 32'h0000FFFE);
    req[0][0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      data[0][7:0] = 8'(8'h10 + j);
      expect_ack(0, 0, 1, 8'(8'h10 + j), 1);
      tick(); tick();
    end
    req[0][0] = 1'b0;
    tick(); tick();

    // Latency 1: req gone in ACK cycle -> ack but no capture.
    data[0][15:8] = 8'hEE; req[0][1] = 1'b1;
    expect_ack(0, 1, 1, 8'hEE, 0);
    tick();
    req[0][1] = 1'b0;
    tick(); tick();
    chk("err after req drop in ACK", 32'(err[0][1]), 32'(CHK));

    // Latency 1: stall in IDLE diverts through WAIT.
    stall[0][1] = 1'b1; req[0][1] = 1'b1; data[0][15:8] = 8'h77;
    expect_ack(0, 1, 3, 8'h77, 1);
    tick(); tick();
    stall[0][1] = 1'b0;
    tick(); tick();
    req[0][1] = 1'b0;
    tick(); tick();

    // Latency 3: baseline on ch1, then stalled transfer on ch0.
    data[1][15:8] = 8'h3C; req[1][1] = 1'b1;
    expect_ack(1, 1, 3, 8'h3C, 1);
    repeat (4) tick();
    req[1][1] = 1'b0;
    tick();
    data[1][7:0] = 8'hA5; req[1][0] = 1'b1; stall[1][0] = 1'b1;
    expect_ack(1, 0, 6, 8'hA5, 1);
    repeat (5) tick();
    stall[1][0] = 1'b0;
    repeat (2) tick();
    req[1][0] = 1'b0;
    repeat (2) tick();

    // Latency 4: req held on ch1 -> pulses at 4, 9, 14.
    data[2][15:8] = 8'h42; req[2][1] = 1'b1;
    for (int j = 0; j < 3; j++) expect_ack(2, 1, 4 + 5 * j, 8'h42, 1);
    repeat (15) tick();
    req[2][1] = 1'b0;
    repeat (2) tick();

    // Latency 4: req dropped in WAIT.
    data[2][7:0] = 8'hBB; req[2][0] = 1'b1;
    repeat (2) tick();
    req[2][0] = 1'b0;
    repeat (6) tick();
    chk("abort cnt",  32'(cnt[2][15:0]), 32'd0);
    chk("abort last", 32'(last[2][7:0]), 32'd0);
    chk("abort err",  32'(err[2][0]),    32'(CHK));
    chk("abort err other ch", 32'(err[2][1]), 32'd0);

    // Latency 4: reset while in WAIT clears everything.
    data[2][7:0] = 8'hCD; req[2][0] = 1'b1;
    repeat (2) tick();
    rst[2] = 1'b1; req[2][0] = 1'b0;
    tick();
    rst[2] = 1'b0;
    reset_model(2);
    chk("rst ack",  32'(ack[2]),  32'd0);
    chk("rst last", 32'(last[2]), 32'd0);
    chk("rst cnt",  cnt[2],       32'd0);
    chk("rst err",  32'(err[2]),  32'd0);
    data[2][7:0] = 8'h99; req[2][0] = 1'b1;
    expect_ack(2, 0, 4, 8'h99, 1);
    repeat (5) tick();
    req[2][0] = 1'b0;
    repeat (3) tick();

    chk("err sticky", 32'(err[0][1]), 32'(CHK));
    for (int k = 0; k < 6; k++)
      chk($sformatf("missing_ack i%0d ch%0d", k/2, k%2), 32'(sb[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
